regfile_wb_arbiter: RTL

- Shares the register file's single write port among three writeback requesters: 0 = ALU, 1 = multiplier/divider, 2 = memory load.
- Round-robin grant with a valid/ready handshake per requester.
- Drives a registered write port (enable, register index, data) straight into the register file.
- Keeps a 32-entry pending-write scoreboard so the decode stage can stall reads of registers whose writeback has not landed.

---
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among three writeback
// requesters, with a per-register pending-write scoreboard for decode stalls.
module regfile_wb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int REG_BITS  = 5,
    parameter int DATA_BITS = 32
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic [NUM_REQ-1:0]             wb_valid,
    input  logic [NUM_REQ*REG_BITS-1:0]    wb_reg,
    input  logic [NUM_REQ*DATA_BITS-1:0]   wb_data,
    output logic [NUM_REQ-1:0]             wb_ready,
    input  logic                           issue_valid,
    input  logic [REG_BITS-1:0]            issue_reg,
    input  logic [REG_BITS-1:0]            ctrl_readRegA,
    input  logic [REG_BITS-1:0]            ctrl_readRegB,
    output logic                           stall_a,
    output logic                           stall_b,
    output logic                           ctrl_writeEnable,
    output logic [REG_BITS-1:0]            ctrl_writeReg,
    output logic [DATA_BITS-1:0]           data_writeReg
);
    localparam int NUM_REG = 1 << REG_BITS;

    logic [1:0]           lastReg;
    logic [NUM_REG-1:0]   pendingReg;
    logic [1:0]           grantIdx;
    logic                 grantAny;
    logic [1:0]           cand;
    logic                 transfer;

    logic [REG_BITS-1:0]  reqReg  [NUM_REQ];
    logic [DATA_BITS-1:0] reqData [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reqReg[gi]  = wb_reg[gi*REG_BITS +: REG_BITS];
            assign reqData[gi] = wb_data[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    // Search starts just after the last winner, so each requester waits at most two grants.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = 2'd0;
        cand     = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 2'((int'(lastReg) + k + 1) % NUM_REQ);
            if (!grantAny && wb_valid[cand]) begin
                grantAny = 1'b1;
                grantIdx = cand;
            end
        end
    end

    assign transfer = grantAny && !ctrl_reset;
    assign wb_ready = transfer ? (NUM_REQ'(1) << grantIdx) : '0;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            lastReg          <= 2'd2;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (transfer) begin
            lastReg          <= grantIdx;
            ctrl_writeEnable <= |reqReg[grantIdx];
            ctrl_writeReg    <= reqReg[grantIdx];
            data_writeReg    <= reqData[grantIdx];
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // A new issue beats a landing write to the same register: the issue is younger.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            pendingReg <= '0;
        end else begin
            pendingReg[0] <= 1'b0;
            for (int r = 1; r < NUM_REG; r++) begin
                if (issue_valid && issue_reg == REG_BITS'(r))
                    pendingReg[r] <= 1'b1;
                else if (ctrl_writeEnable && ctrl_writeReg == REG_BITS'(r))
                    pendingReg[r] <= 1'b0;
            end
        end
    end

    assign stall_a = pendingReg[ctrl_readRegA];
    assign stall_b = pendingReg[ctrl_readRegB];

endmodule
